// File: rtl/kronos_alu_seq.sv
// kronos_alu_seq: multi-cycle RV32I ALU with a valid/ready handshake on both sides,
// a registered result, and an iterative shifter that moves up to SHIFT_STEP bits per cycle.
module kronos_alu_seq #(
    parameter int WIDTH      = 32,
    parameter int SHIFT_STEP = 4
) (
    input  logic             clk,
    input  logic             rstz,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [3:0]       aluop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;   // one extra bit so a step of WIDTH is representable
    localparam logic [CW-1:0] STEP = CW'(SHIFT_STEP);

    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b1101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    remaining;
    logic             sh_left;
    logic             sh_fill;

    logic             accept;
    logic             is_shift;
    logic [CW-1:0]    shamt;
    logic [CW-1:0]    step_amt;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] fill_mask;
    logic [WIDTH-1:0] shifted;

    assign in_ready = !flush && (state == IDLE || (state == DONE && out_ready));
    assign accept   = in_valid && in_ready;
    assign shamt    = {1'b0, op2[SHW-1:0]};
    assign is_shift = (aluop == OP_SLL) || (aluop == OP_SRL) || (aluop == OP_SRA);

    always_comb begin
        // NOTE: a default assignment before the case keeps every path driven, so no latch is inferred.
        alu_res = op1 + op2;
        case (aluop)
            OP_SUB:  alu_res = op1 - op2;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(op1) < $signed(op2)};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, op1 < op2};
            OP_XOR:  alu_res = op1 ^ op2;
            OP_OR:   alu_res = op1 | op2;
            OP_AND:  alu_res = op1 & op2;
            OP_SLL, OP_SRL, OP_SRA: alu_res = op1;  // only taken for a zero shift amount
            default: ;
        endcase
    end

    // One shifter step: the smaller of the per-cycle budget and what is left.
    assign step_amt  = (remaining > STEP) ? STEP : remaining;
    assign fill_mask = sh_fill ? ~({WIDTH{1'b1}} >> step_amt) : '0;
    assign shifted   = sh_left ? (shreg << step_amt) : ((shreg >> step_amt) | fill_mask);

    // NOTE: non-blocking assignments throughout, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            // NOTE: the datapath registers are reset too, so no stale or partial result survives reset.
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            shreg     <= '0;
            remaining <= '0;
            sh_left   <= 1'b0;
            sh_fill   <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            remaining <= '0;
        end else if (accept) begin
            if (is_shift && shamt != '0) begin
                shreg     <= op1;
                remaining <= shamt;
                sh_left   <= (aluop == OP_SLL);
                sh_fill   <= (aluop == OP_SRA) && op1[WIDTH-1];
                state     <= SHIFT;
                out_valid <= 1'b0;
            end else begin
                result    <= alu_res;
                state     <= DONE;
                out_valid <= 1'b1;
            end
        end else begin
            case (state)
                SHIFT: begin
                    shreg     <= shifted;
                    remaining <= remaining - step_amt;
                    if (remaining == step_amt) begin
                        result    <= shifted;
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/kronos_alu_seq.md
Name: kronos_alu_seq

Overview:
- Parametrised, multi-cycle successor to the Kronos combinational ALU; same RV32I op set and 4-bit aluop encoding, generalised to WIDTH bits.
- Adds a valid/ready handshake on input and output, a registered result, an iterative shifter of SHIFT_STEP bits/cycle and a synchronous flush.
- Sits between decode and writeback in area-constrained Kronos variants that do not want a full barrel shifter.

Parameters:
WIDTH, 32, datapath width; power of 2, >= 8; SHW = $clog2(WIDTH)
SHIFT_STEP, 4, max shift distance per cycle; power of 2, 1..WIDTH (WIDTH gives single-step shifts)

Ports:
clk  in  1  clock, all state on rising edge
rstz  in  1  asynchronous active-low reset
flush  in  1  synchronous abort of any in-flight/held op
in_valid  in  1  op1/op2/aluop valid
in_ready  out  1  block can accept an op this cycle
op1  in  WIDTH  operand 1
op2  in  WIDTH  operand 2; shamt = op2[SHW-1:0]
aluop  in  4  ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111
out_valid  out  1  result valid
out_ready  in  1  consumer takes result
result  out  WIDTH  registered result

Behaviour:
- Reset (rstz low, async): state=IDLE, out_valid=0, result=0, shift count=0. in_ready=1 after reset.
- States:
  - IDLE: no op held.
  - SHIFT: iterating.
  - DONE: out_valid=1, result held.
- in_ready = !flush && (IDLE || (DONE && out_ready)). Accept = in_valid && in_ready; operands are captured at accept (cycle T) only.
- Single-cycle ops (ADD, SUB, logic, SLT, SLTU) and shifts with shamt==0:
  - result registered at T; out_valid=1 from T+1.
  - Next state DONE.
- Shift ops with shamt>0:
  - At T: load op1 into the shift register, remaining=shamt. Next state SHIFT.
  - In SHIFT: each cycle shift by min(SHIFT_STEP, remaining) and decrement remaining.
  - When remaining reaches 0: write result, go to DONE.
  - out_valid rises at T+1+ceil(shamt/SHIFT_STEP).
- Shift fill rules:
  - SLL: zeros in at LSB.
  - SRL: zeros in at MSB.
  - SRA: op1[WIDTH-1] captured at accept is filled in at MSB.
- Arithmetic: WIDTH-bit modular ADD/SUB, with no carry or overflow output.
  - SLTU = op1 <u op2.
  - SLT = signed compare using bit WIDTH-1.
  - SLT/SLTU result is zero-extended 0/1.
- Unlisted aluop encodings execute as ADD (single-cycle).
- DONE with out_ready=0: result and out_valid held stable; in_ready=0.
- DONE with out_ready=1 and no accept: next state IDLE, out_valid=0.
- DONE with out_ready=1 and accept in the same cycle: the new op is processed and the old result retires.
  - Throughput is 1 op/cycle for single-cycle ops.
- flush: highest priority after reset.
  - Next state IDLE, out_valid=0 next cycle; the shift op is discarded; in_ready=0 during the flush cycle.
  - result register holds its last value.
- Reset mid-shift: immediate return to reset values; no partial result is ever presented.
- in_valid while in_ready=0 is ignored; the source must hold.

Test Plan (WIDTH=32, SHIFT_STEP=4):
- ADD op1=0x7FFFFFFF, op2=1 accepted at T -> result=0x80000000, out_valid at T+1. SUB 3-5 back-to-back with out_ready=1 -> 0xFFFFFFFE at T+2.
- SLT op1=0xFFFFFFFF, op2=1 -> 1. SLTU same operands -> 0. Unlisted aluop 1111, 2+3 -> 5.
- SRA op1=0x80000000, op2=5 at T -> in_ready=0 at T+1..T+2; out_valid at T+3 with result=0xFC000000.
- SLL op1=1, op2=31 -> out_valid at T+9, result=0x80000000.
  - SRL op1=0x1234, op2=32 (shamt=0) -> 0x1234 at T+1.
  - SHIFT_STEP=32 build: any shift -> T+2.
- Backpressure: AND result held 3 cycles with out_ready=0 -> result/out_valid stable, in_ready=0. Then out_ready=1 with in_valid=1, OR op -> accepted same cycle, OR result at next cycle.
- SRL shamt=20 with flush at T+2 -> out_valid=0 from T+3, IDLE, in_ready=1 at T+3.
  - rstz pulse at T+2 of the same op -> out_valid=0, result=0 immediately; no stale result.
